alm_mac_acc: RTL

Signed accumulator placed directly downstream of the 16x16 approximate log multiplier. It takes a stream of 32-bit products in the multiplier's native sign format: negative results are the ones' complement of the magnitude, flagged by the product sign bit. Each product is corrected to two's complement and summed, with saturation, over a packet delimited by `p_last_i`. At the end of each packet the block emits one registered dot-product result on a valid/ready interface.

---
 rtl/alm_mac_acc.sv | 103 ++++++++++
 1 files changed

// File: rtl/alm_mac_acc.sv
// Saturating signed accumulator for the approximate log multiplier's ones'-complement
// products; emits one registered packet sum per p_last_i on a valid/ready port.
module alm_mac_acc #(
    parameter int ACC_W = 40,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [31:0]      p_i,
    input  logic             p_sign_i,
    input  logic             p_valid_i,
    input  logic             p_last_i,
    output logic             p_ready_o,
    input  logic             clr_i,
    output logic [ACC_W-1:0] sum_o,
    output logic [CNT_W-1:0] count_o,
    output logic             sat_o,
    output logic             sum_valid_o,
    input  logic             sum_ready_i
);

    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic {EMPTY, FULL} state_t;

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             sat;

    logic [ACC_W-1:0] q;
    logic [ACC_W:0]   sum_wide;
    logic             ovf;
    logic [ACC_W-1:0] acc_next;
    logic [CNT_W-1:0] cnt_next;
    logic             take;
    logic             close;

    assign p_ready_o = ~sum_valid_o | sum_ready_i;
    assign take      = p_valid_i & p_ready_o;
    assign close     = take & p_last_i & ~clr_i;

    // Ones' complement negative -> two's complement; a zero product stays zero.
    assign q = {{(ACC_W-32){p_i[31]}}, p_i} + ACC_W'(p_sign_i & (|p_i));

    assign sum_wide = {acc[ACC_W-1], acc} + {q[ACC_W-1], q};
    assign ovf      = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];

    always_comb begin
        acc_next = sum_wide[ACC_W-1:0];
        if (ovf)
            acc_next = sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
    end

    assign cnt_next = (&cnt) ? cnt : cnt + CNT_W'(1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= EMPTY;
            sum_valid_o <= 1'b0;
            sum_o       <= '0;
            count_o     <= '0;
            sat_o       <= 1'b0;
            acc         <= '0;
            cnt         <= '0;
            sat         <= 1'b0;
        end else begin
            if (clr_i || close) begin
                acc <= '0;
                cnt <= '0;
                sat <= 1'b0;
            end else if (take) begin
                acc <= acc_next;
                cnt <= cnt_next;
                sat <= sat | ovf;
            end

            if (close) begin
                sum_o   <= acc_next;
                count_o <= cnt_next;
                sat_o   <= sat | ovf;
            end

            // Drain and reload on the same edge keeps the result slot FULL.
            case (state)
                EMPTY: if (close) begin
                    state       <= FULL;
                    sum_valid_o <= 1'b1;
                end
                FULL: if (sum_ready_i && !close) begin
                    state       <= EMPTY;
                    sum_valid_o <= 1'b0;
                end
                default: begin
                    state       <= EMPTY;
                    sum_valid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
